// File: rtl/slice_line_reader_if.sv
// Handshake bundle for slice_line_reader: ingress line stream, start/status and egress line stream.
// The parity pair exists only when SLICE_READER_PARITY_EN is defined.
interface slice_line_reader_if #(
    parameter int N  = 25,
    parameter int AW = 6
);
    logic          in_valid;
    logic [N-1:0]  in_line;
    logic          in_ready;
    logic          load_done;
    logic          start;
    logic          out_valid;
    logic [N-1:0]  out_line;
    logic [AW-1:0] out_index;
    logic          out_en;
    logic          done;
    logic          busy;
`ifdef SLICE_READER_PARITY_EN
    logic          in_par;
    logic          par_err;

    modport slave (
        input  in_valid, in_line, in_par, start, out_en,
        output in_ready, load_done, out_valid, out_line, out_index, done, busy, par_err
    );
    modport master (
        output in_valid, in_line, in_par, start, out_en,
        input  in_ready, load_done, out_valid, out_line, out_index, done, busy, par_err
    );
`else
    modport slave (
        input  in_valid, in_line, start, out_en,
        output in_ready, load_done, out_valid, out_line, out_index, done, busy
    );
    modport master (
        output in_valid, in_line, start, out_en,
        input  in_ready, load_done, out_valid, out_line, out_index, done, busy
    );
`endif
endinterface

// File: rtl/slice_line_reader.sv
// Ingress line buffer for the permute stage: loads 64 slice lines (slice 63 first), then streams them back out.
// Optional ingress parity check enabled by defining SLICE_READER_PARITY_EN.
module slice_line_reader #(
    parameter int N     = 25,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic               clk,
    input  logic               rst,
    slice_line_reader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_FULL     = 2'd1,
        ST_PREFETCH = 2'd2,
        ST_STREAM   = 2'd3
    } state_t;

    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_ZERO = AW'(0);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    state_t        state_q;
    logic [AW-1:0] wr_idx_q;
    logic [AW-1:0] rd_idx_q;
    logic [AW-1:0] wr_idx_d;
    logic [AW-1:0] rd_idx_d;
    logic          in_ready_q;
    logic          load_done_q;
    logic          out_valid_q;
    logic          done_q;
    logic          busy_q;
    logic [N-1:0]  out_line_q;
    logic [AW-1:0] out_index_q;
    logic [N-1:0]  mem [DEPTH];
    logic          wr_fire_s;
    logic          rd_fire_s;

    assign wr_fire_s = (state_q == ST_LOAD) && bus.in_valid && in_ready_q;
    assign rd_fire_s = (state_q == ST_STREAM) && out_valid_q && bus.out_en;
    assign wr_idx_d  = wr_idx_q - IDX_ONE;
    assign rd_idx_d  = rd_idx_q - IDX_ONE;

    assign bus.in_ready  = in_ready_q;
    assign bus.load_done = load_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_line  = out_line_q;
    assign bus.out_index = out_index_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

    // Line memory write port; contents are never reset and rst suppresses a coincident write.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire_s) begin
            mem[wr_idx_q] <= bus.in_line;
        end
    end

    // Control FSM; the read of the next line is issued in the accept cycle so streaming has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_idx_q    <= IDX_LAST;
            rd_idx_q    <= IDX_LAST;
            in_ready_q  <= 1'b1;
            load_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_line_q  <= {N{1'b0}};
            out_index_q <= IDX_LAST;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (wr_fire_s) begin
                        if (wr_idx_q == IDX_ZERO) begin
                            state_q     <= ST_FULL;
                            wr_idx_q    <= IDX_LAST;
                            in_ready_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_d;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.start) begin
                        state_q     <= ST_PREFETCH;
                        load_done_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_PREFETCH: begin
                    out_line_q  <= mem[rd_idx_q];
                    out_index_q <= rd_idx_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (rd_fire_s) begin
                        if (rd_idx_q == IDX_ZERO) begin
                            state_q     <= ST_LOAD;
                            rd_idx_q    <= IDX_LAST;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            rd_idx_q    <= rd_idx_d;
                            out_line_q  <= mem[rd_idx_d];
                            out_index_q <= rd_idx_d;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_LOAD;
                    wr_idx_q    <= IDX_LAST;
                    rd_idx_q    <= IDX_LAST;
                    in_ready_q  <= 1'b1;
                    load_done_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SLICE_READER_PARITY_EN
    function automatic logic line_parity(input logic [N-1:0] line);
        return ^line;
    endfunction

    logic par_err_q;

    assign bus.par_err = par_err_q;

    // Sticky ingress parity flag, cleared when the stream completes and the block re-enters LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (rd_fire_s && (rd_idx_q == IDX_ZERO)) begin
            par_err_q <= 1'b0;
        end else if (wr_fire_s && (line_parity(bus.in_line) != bus.in_par)) begin
            par_err_q <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_slice_line_reader.sv
// Directed bench for slice_line_reader; a negedge monitor checks streamed lines against a queue of expected lines.
module tb_slice_line_reader;
    localparam int N     = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [N-1:0]  line;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    logic prev_acc0 = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;
`ifdef SLICE_READER_PARITY_EN
    logic par_expect = 1'b0;
`endif

    always #5 clk = ~clk;

    slice_line_reader_if #(.N(N), .AW(AW)) bus ();

    slice_line_reader #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Line patterns; slice s of pattern p.
    function automatic logic [N-1:0] pat(input int p, input int s);
        logic [5:0] s6;
        s6 = 6'(s);
        case (p)
            1:       return 25'(s);
            2:       return {19'(s * 7 + 3), s6};
            3:       return 25'h1F00000 | {11'd0, s6, 8'd0} | {19'd0, ~s6};
            default: return 25'h0AAAAAA ^ 25'(s);
        endcase
    endfunction

    task automatic drive_line(input logic [N-1:0] l);
        bus.in_line = l;
`ifdef SLICE_READER_PARITY_EN
        bus.in_par = (l == 25'h0000001) ? 1'b0 : ^l;
`endif
    endtask

    task automatic load_state(input int p, input int nlines, input bit toggle);
        int  k     = 0;
        int  guard = 0;
        bit  gap   = 1'b0;
        bit  acc;
        while (k < nlines && guard < 400) begin
            if (toggle && gap) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                drive_line(pat(p, 63 - k));
                chk("in_ready_load", 32'(bus.in_ready), 32'd1);
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc && k == 63) chk("load_done_early", 32'(bus.load_done), 32'd0);
            @(posedge clk); #1;
            if (acc) k++;
            gap = ~gap;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("load_count", 32'(k), 32'(nlines));
    endtask

    task automatic run_stream(input int p, input int stall_at, input int stall_len);
        int cyc     = 0;
        int stalled = 0;
        int pops0   = pops;
        for (int s = 63; s >= 0; s--) exp_q.push_back(exp_t'({6'(s), pat(p, s)}));
        bus.start  = 1'b1;
        bus.out_en = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("prefetch_valid", 32'(bus.out_valid), 32'd0);
        chk("prefetch_busy", 32'(bus.busy), 32'd1);
        chk("load_done_clr", 32'(bus.load_done), 32'd0);
        @(posedge clk); #1;
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_index", 32'(bus.out_index), 32'd63);
        while (!bus.done && cyc < 300) begin
            if (bus.out_valid && int'(bus.out_index) == stall_at && stalled < stall_len) begin
                bus.out_en = 1'b0;
                chk("stall_index", 32'(bus.out_index), 32'(stall_at));
                chk("stall_line", 32'(bus.out_line), 32'(pat(p, stall_at)));
                stalled++;
            end else begin
                bus.out_en = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        chk("stream_cycles", 32'(cyc), 32'(64 + stall_len));
        chk("stream_pops", 32'(pops - pops0), 32'd64);
        chk("done_in_ready", 32'(bus.in_ready), 32'd1);
        chk("done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd0);
        bus.out_en = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic check_idle_after_reset();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_load_done", 32'(bus.load_done), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_index", 32'(bus.out_index), 32'd63);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SLICE_READER_PARITY_EN
        chk("rst_par_err", 32'(bus.par_err), 32'd0);
`endif
    endtask

    // Monitor: pops the expected line on every accepted beat and checks done follows the slice-0 accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_acc0 || bus.done) chk("done_after_last", 32'(bus.done), 32'(prev_acc0));
`ifdef SLICE_READER_PARITY_EN
            if (bus.out_valid) chk("par_err_stream", 32'(bus.par_err), 32'(par_expect));
`endif
            if (bus.out_valid && bus.out_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_line", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_index", 32'(bus.out_index), 32'(mon_e.idx));
                    chk("out_line", 32'(bus.out_line), 32'(mon_e.line));
                    pops++;
                end
            end
            prev_acc0 = bus.out_valid && bus.out_en && (bus.out_index == 6'd0);
        end else begin
            prev_acc0 = 1'b0;
        end
    end

    initial begin
        int pops0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_line  = 25'd0;
        bus.start    = 1'b0;
        bus.out_en   = 1'b0;
`ifdef SLICE_READER_PARITY_EN
        bus.in_par   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_idle_after_reset();
        chk("rst_out_line", 32'(bus.out_line), 32'd0);
        rst = 1'b0;

        // Full load with in_valid held high, then in_valid in FULL must be ignored.
        load_state(1, 64, 1'b0);
        chk("full_load_done", 32'(bus.load_done), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef SLICE_READER_PARITY_EN
        chk("par_err_set", 32'(bus.par_err), 32'd1);
        par_expect = 1'b1;
`endif
        bus.in_valid = 1'b1;
        drive_line(pat(4, 5));
        repeat (3) begin
            @(posedge clk); #1;
            chk("full_hold_ready", 32'(bus.in_ready), 32'd0);
            chk("full_hold_done", 32'(bus.load_done), 32'd1);
        end
        bus.in_valid = 1'b0;
        run_stream(1, 40, 5);
`ifdef SLICE_READER_PARITY_EN
        chk("par_err_clr", 32'(bus.par_err), 32'd0);
        par_expect = 1'b0;
`endif

        // Load with in_valid toggling; streaming at full rate.
        load_state(2, 64, 1'b1);
        chk("tog_load_done", 32'(bus.load_done), 32'd1);
        run_stream(2, -1, 0);

        // Reset after a partial load, start in LOAD ignored, then a full reload.
        load_state(4, 30, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_after_reset();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            chk("load_start_valid", 32'(bus.out_valid), 32'd0);
            chk("load_start_busy", 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
        end
        load_state(3, 64, 1'b0);
        run_stream(3, 17, 2);

        // Reset in the middle of a stream.
        load_state(2, 64, 1'b0);
        pops0 = pops;
        for (int s = 63; s >= 0; s--) exp_q.push_back(exp_t'({6'(s), pat(2, s)}));
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        @(posedge clk); #1;
        bus.out_en = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.out_en = 1'b0;
        exp_q.delete();
        chk("mid_pops", 32'(pops - pops0), 32'd10);
        check_idle_after_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
